score_scheduler: RTL and testbench

Shared-score controller for the two-player co-op mode. Accepts hit events from both players, buffers one pending event per player, and round-robin arbitrates between them. It then sequences the granted addition into a chain of decimal score digits, applying the points to digit 0 and rippling the carry one digit per cycle. It sits between the step-judging logic and the score display decoders.

---
 rtl/score_pkg.sv | 31 +++
 rtl/bcd_digit.sv | 38 +++
 rtl/score_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_score_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and helpers for the co-op score scheduler.
package score_pkg;

    // Scheduler FSM states: IDLE grants pending events, CARRY ripples one digit per cycle.
    typedef enum logic {
        IDLE  = 1'b0,
        CARRY = 1'b1
    } state_e;

    // Width of one BCD digit.
    localparam int BCD_W = 4;

    // Player indices into GRANT / DROP / slot arrays.
    localparam int P1 = 0;
    localparam int P2 = 1;

    // Modulo-10 digit add; bit BCD_W is the decimal carry-out.
    function automatic logic [BCD_W:0] bcd_add(input logic [BCD_W-1:0] a,
                                               input logic [BCD_W-1:0] b);
        logic [BCD_W:0] sum;
        logic [BCD_W:0] wrapped;
        sum     = {1'b0, a} + {1'b0, b};
        wrapped = sum - 5'd10;
        if (sum >= 5'd10) begin
            bcd_add = {1'b1, wrapped[BCD_W-1:0]};
        end else begin
            bcd_add = {1'b0, sum[BCD_W-1:0]};
        end
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal score digit: holds 0-9, adds modulo 10 when enabled, reports carry-out.
module bcd_digit
    import score_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [BCD_W-1:0] add_i,
    input  logic             load_zero_i,
    input  logic             en_i,
    output logic [BCD_W-1:0] value_o,
    output logic             carry_o
);

    logic [BCD_W-1:0] value_q;
    logic [BCD_W:0]   sum_s;

    // Sum of current value and add amount; carry only meaningful while enabled.
    always_comb begin
        sum_s   = bcd_add(value_q, add_i);
        carry_o = en_i & sum_s[BCD_W];
    end

    // Digit register: clear has priority over an enabled add.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= 4'd0;
        end else if (load_zero_i) begin
            value_q <= 4'd0;
        end else if (en_i) begin
            value_q <= sum_s[BCD_W-1:0];
        end else begin
            value_q <= value_q;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/score_scheduler.sv
// Two-player shared score: per-player pending slots, round-robin grant,
// and a BCD digit chain whose carry ripples one digit per cycle.
module score_scheduler
    import score_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int GOOD_PTS    = 1,
    parameter int PERFECT_PTS = 2
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  CLEAR,
    input  logic                  P1_GOOD,
    input  logic                  P1_PERFECT,
    input  logic                  P2_GOOD,
    input  logic                  P2_PERFECT,
    output logic [4*DIGITS-1:0]   SCORE,
    output logic [1:0]            GRANT,
    output logic [1:0]            DROP,
    output logic                  BUSY,
    output logic                  WRAP
);

    localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e                 state_q;
    logic [KW-1:0]          k_q;
    logic                   last_p2_q;   // last granted player was P2 (reset => P1 priority)
    logic                   wrap_q;
    logic [1:0]             slot_vld_q;
    logic [1:0][BCD_W-1:0]  slot_pts_q;

    logic [1:0]             ev_s;
    logic [1:0][BCD_W-1:0]  ev_pts_s;
    logic [1:0]             grant_s;
    logic [1:0]             cap_s;
    logic [1:0]             drop_s;
    logic [BCD_W-1:0]       win_pts_s;
    logic [DIGITS-1:0]      dig_en_s;
    logic [BCD_W-1:0]       dig_add_s [DIGITS];
    logic [BCD_W-1:0]       dig_val_s [DIGITS];
    logic [DIGITS-1:0]      dig_carry_s;
    logic                   carry_sel_s;

    // Decode hit pulses; a perfect hit outranks a simultaneous good hit.
    always_comb begin
        ev_s[P1]     = P1_GOOD | P1_PERFECT;
        ev_s[P2]     = P2_GOOD | P2_PERFECT;
        ev_pts_s[P1] = P1_PERFECT ? 4'(PERFECT_PTS) : 4'(GOOD_PTS);
        ev_pts_s[P2] = P2_PERFECT ? 4'(PERFECT_PTS) : 4'(GOOD_PTS);
    end

    // Round-robin arbitration, only in IDLE and never during a clear.
    always_comb begin
        grant_s = 2'b00;
        if (!CLEAR && (state_q == IDLE)) begin
            case (slot_vld_q)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = last_p2_q ? 2'b01 : 2'b10;
                default: grant_s = 2'b00;
            endcase
        end else begin
            grant_s = 2'b00;
        end
        win_pts_s = grant_s[P2] ? slot_pts_q[P2] : slot_pts_q[P1];
    end

    // Slot capture vs. drop: a slot being granted this cycle can take a new event.
    always_comb begin
        cap_s  = 2'b00;
        drop_s = 2'b00;
        for (int p = 0; p < 2; p++) begin
            if (!CLEAR && ev_s[p]) begin
                if (!slot_vld_q[p] || grant_s[p]) begin
                    cap_s[p] = 1'b1;
                end else begin
                    drop_s[p] = 1'b1;
                end
            end else begin
                cap_s[p]  = 1'b0;
                drop_s[p] = 1'b0;
            end
        end
    end

    // Digit enables: granted points go to digit 0, carry adds 1 to digit k.
    always_comb begin
        dig_en_s    = '0;
        carry_sel_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            dig_add_s[i] = 4'd0;
            if ((state_q == IDLE) && (grant_s != 2'b00) && (i == 0)) begin
                dig_en_s[i]  = 1'b1;
                dig_add_s[i] = win_pts_s;
            end else if ((state_q == CARRY) && (KW'(i) == k_q)) begin
                dig_en_s[i]  = 1'b1;
                dig_add_s[i] = 4'd1;
            end else begin
                dig_en_s[i]  = 1'b0;
                dig_add_s[i] = 4'd0;
            end
            if (KW'(i) == k_q) begin
                carry_sel_s = dig_carry_s[i];
            end else begin
                carry_sel_s = carry_sel_s;
            end
        end
    end

    // Pending-slot registers.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            slot_vld_q <= 2'b00;
            slot_pts_q <= '0;
        end else if (CLEAR) begin
            slot_vld_q <= 2'b00;
            slot_pts_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (cap_s[p]) begin
                    slot_vld_q[p] <= 1'b1;
                    slot_pts_q[p] <= ev_pts_s[p];
                end else if (grant_s[p]) begin
                    slot_vld_q[p] <= 1'b0;
                end else begin
                    slot_vld_q[p] <= slot_vld_q[p];
                end
            end
        end
    end

    // Scheduler FSM with carry index, round-robin pointer and registered WRAP.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            k_q       <= '0;
            last_p2_q <= 1'b1;
            wrap_q    <= 1'b0;
        end else if (CLEAR) begin
            state_q   <= IDLE;
            k_q       <= '0;
            last_p2_q <= 1'b1;
            wrap_q    <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_s != 2'b00) begin
                        last_p2_q <= grant_s[P2];
                        if (dig_carry_s[0]) begin
                            state_q <= CARRY;
                            k_q     <= KW'(1);
                        end
                    end
                end
                CARRY: begin
                    if (carry_sel_s) begin
                        if (k_q == KW'(DIGITS - 1)) begin
                            wrap_q  <= 1'b1;
                            state_q <= IDLE;
                            k_q     <= '0;
                        end else begin
                            k_q <= k_q + KW'(1);
                        end
                    end else begin
                        state_q <= IDLE;
                        k_q     <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    k_q     <= '0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk_i       (CLOCK),
            .rst_ni      (RESET),
            .add_i       (dig_add_s[g]),
            .load_zero_i (CLEAR),
            .en_i        (dig_en_s[g]),
            .value_o     (dig_val_s[g]),
            .carry_o     (dig_carry_s[g])
        );
        assign SCORE[4*g +: 4] = dig_val_s[g];
    end

    assign GRANT = grant_s;
    assign DROP  = drop_s;
    assign BUSY  = (state_q == CARRY);
    assign WRAP  = wrap_q;

endmodule

// File: tb/tb_score_scheduler.sv
// Directed bench for score_scheduler with hand-computed expectations.
module tb_score_scheduler;

    logic        CLOCK;
    logic        RESET;
    logic        CLEAR;
    logic        P1_GOOD, P1_PERFECT, P2_GOOD, P2_PERFECT;
    logic [15:0] SCORE;
    logic [1:0]  GRANT, DROP;
    logic        BUSY, WRAP;

    int          n_vec;
    int          n_bad;
    logic [1:0]  gnt_seen, drp_seen, drop_acc;
    int          busy_cnt, wrap_cnt;

    score_scheduler #(.DIGITS(4), .GOOD_PTS(1), .PERFECT_PTS(2)) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .CLEAR      (CLEAR),
        .P1_GOOD    (P1_GOOD),
        .P1_PERFECT (P1_PERFECT),
        .P2_GOOD    (P2_GOOD),
        .P2_PERFECT (P2_PERFECT),
        .SCORE      (SCORE),
        .GRANT      (GRANT),
        .DROP       (DROP),
        .BUSY       (BUSY),
        .WRAP       (WRAP)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample combinational outputs mid-cycle,
    // then sample registered outputs 1 time unit after the edge.
    task automatic step(input logic p1g, input logic p1p, input logic p2g,
                        input logic p2p, input logic clr);
        P1_GOOD = p1g; P1_PERFECT = p1p; P2_GOOD = p2g; P2_PERFECT = p2p; CLEAR = clr;
        #2;
        gnt_seen = GRANT;
        drp_seen = DROP;
        drop_acc = drop_acc | DROP;
        @(posedge CLOCK);
        #1;
        P1_GOOD = 1'b0; P1_PERFECT = 1'b0; P2_GOOD = 1'b0; P2_PERFECT = 1'b0; CLEAR = 1'b0;
        if (BUSY) busy_cnt++;
        if (WRAP) wrap_cnt++;
    endtask

    // Single P1 event, granted, then wait out any carry.
    task automatic add_p1(input logic perf);
        int n;
        step(!perf, perf, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (BUSY && n < 10) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        if (n >= 10) chk_vec("busy_timeout", 32'd1, 32'd0);
    endtask

    // Clear, then nine back-to-back P1 good hits -> 0009.
    task automatic preload9();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drop_acc = 2'b00;
        repeat (9) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_vec("pre9_score", {16'd0, SCORE}, 32'h0009);
        chk_vec("pre9_drop", {30'd0, drop_acc}, 32'd0);
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        busy_cnt = 0; wrap_cnt = 0; drop_acc = 2'b00;
        gnt_seen = 2'b00; drp_seen = 2'b00;
        CLEAR = 1'b0; P1_GOOD = 1'b0; P1_PERFECT = 1'b0; P2_GOOD = 1'b0; P2_PERFECT = 1'b0;
        RESET = 1'b0;
        #3;
        chk_vec("rst_score", {16'd0, SCORE}, 32'd0);
        chk_vec("rst_grant", {30'd0, GRANT}, 32'd0);
        chk_vec("rst_drop", {30'd0, DROP}, 32'd0);
        chk_vec("rst_busy", {31'd0, BUSY}, 32'd0);
        chk_vec("rst_wrap", {31'd0, WRAP}, 32'd0);
        #9 RESET = 1'b1;
        @(posedge CLOCK);
        #1;

        // Single perfect hit: 0002 after two edges, one grant.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_vec("t1_nogrant_yet", {30'd0, gnt_seen}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_vec("t1_grant", {30'd0, gnt_seen}, 32'b01);
        chk_vec("t1_score", {16'd0, SCORE}, 32'h0002);
        chk_vec("t1_busy", {31'd0, BUSY}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_vec("t1_grant_once", {30'd0, gnt_seen}, 32'd0);

        // 0009 + P2 good -> 0010, one carry cycle delays the next grant.
        preload9();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        busy_cnt = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_vec("t2_grant_p2", {30'd0, gnt_seen}, 32'b10);
        chk_vec("t2_busy", {31'd0, BUSY}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_vec("t2_grant_delayed", {30'd0, gnt_seen}, 32'd0);
        chk_vec("t2_score", {16'd0, SCORE}, 32'h0010);
        chk_vec("t2_busy_cycles", busy_cnt, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_vec("t2_grant_p1", {30'd0, gnt_seen}, 32'b01);
        chk_vec("t2_score2", {16'd0, SCORE}, 32'h0011);

        // Both players every cycle: grants alternate starting with P1.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_vec("t3a_grant", {30'd0, gnt_seen}, 32'd0);
        chk_vec("t3a_drop", {30'd0, drp_seen}, 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_vec("t3b_grant", {30'd0, gnt_seen}, 32'b01);
        chk_vec("t3b_drop", {30'd0, drp_seen}, 32'b10);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_vec("t3c_grant", {30'd0, gnt_seen}, 32'b10);
        chk_vec("t3c_drop", {30'd0, drp_seen}, 32'b01);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_vec("t3d_grant", {30'd0, gnt_seen}, 32'b01);
        chk_vec("t3d_drop", {30'd0, drp_seen}, 32'b10);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_vec("t3e_grant", {30'd0, gnt_seen}, 32'b10);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_vec("t3f_grant", {30'd0, gnt_seen}, 32'b01);
        chk_vec("t3_score", {16'd0, SCORE}, 32'h0005);

        // 0999 + 1 -> 1000: three carry cycles, P2 events during carry.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 999; i++) add_p1(1'b0);
        chk_vec("t4_pre_score", {16'd0, SCORE}, 32'h0999);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        busy_cnt = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_vec("t4_grant", {30'd0, gnt_seen}, 32'b01);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_vec("t4_c1_drop", {30'd0, drp_seen}, 32'd0);
        chk_vec("t4_c1_grant", {30'd0, gnt_seen}, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_vec("t4_c2_drop", {30'd0, drp_seen}, 32'b10);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_vec("t4_c3_drop", {30'd0, drp_seen}, 32'b10);
        chk_vec("t4_c3_grant", {30'd0, gnt_seen}, 32'd0);
        chk_vec("t4_busy_cycles", busy_cnt, 32'd3);
        chk_vec("t4_score", {16'd0, SCORE}, 32'h1000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_vec("t4_grant_p2", {30'd0, gnt_seen}, 32'b10);
        chk_vec("t4_score2", {16'd0, SCORE}, 32'h1001);

        // 9998 + 2 wraps to 0000 with a single WRAP pulse.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4999; i++) add_p1(1'b1);
        chk_vec("t5_pre_score", {16'd0, SCORE}, 32'h9998);
        wrap_cnt = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_vec("t5_grant", {30'd0, gnt_seen}, 32'b01);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_vec("t5_nowrap_early", wrap_cnt, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_vec("t5_wrap", {31'd0, WRAP}, 32'd1);
        chk_vec("t5_score", {16'd0, SCORE}, 32'h0000);
        chk_vec("t5_busy", {31'd0, BUSY}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_vec("t5_wrap_once", wrap_cnt, 32'd1);
        chk_vec("t5_wrap_low", {31'd0, WRAP}, 32'd0);

        // CLEAR during carry with a pending P2 event.
        preload9();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_vec("t6_busy", {31'd0, BUSY}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk_vec("t6_clr_nodrop", {30'd0, drp_seen}, 32'd0);
        chk_vec("t6_clr_score", {16'd0, SCORE}, 32'd0);
        chk_vec("t6_clr_busy", {31'd0, BUSY}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_vec("t6_slots_empty", {30'd0, gnt_seen}, 32'd0);
        chk_vec("t6_score_hold", {16'd0, SCORE}, 32'd0);

        // RESET asserted mid-carry takes effect without a clock edge.
        preload9();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_vec("t7_busy", {31'd0, BUSY}, 32'd1);
        chk_vec("t7_mid_score", {16'd0, SCORE}, 32'h0000);
        #2 RESET = 1'b0;
        #1;
        chk_vec("t7_rst_busy", {31'd0, BUSY}, 32'd0);
        chk_vec("t7_rst_score", {16'd0, SCORE}, 32'd0);
        #3 RESET = 1'b1;
        @(posedge CLOCK);
        #1;
        chk_vec("t7_post_busy", {31'd0, BUSY}, 32'd0);
        chk_vec("t7_post_score", {16'd0, SCORE}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_vec("t7_post_grant", {30'd0, gnt_seen}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
